// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the CPU control unit.
//   state_e       controller state encoding
//   ALU_*         alu_op codes driven to the datapath
//   REG_SRC_*     register-file write source select codes
//   OP_*          bit positions inside the decoder one-hot dec_op
//   decode_next   DECODE-state successor for a given one-hot
package cpu_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StOprd,
    StIn,
    StHalt
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_NOT  = 3'd3;
  localparam logic [2:0] ALU_RSR  = 3'd4;
  localparam logic [2:0] ALU_RSL  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;

  localparam logic [1:0] REG_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_SRC_MEM = 2'd1;
  localparam logic [1:0] REG_SRC_IN  = 2'd2;

  localparam int unsigned OP_MOVA = 15;
  localparam int unsigned OP_MOVB = 14;
  localparam int unsigned OP_MOVC = 13;
  localparam int unsigned OP_ADD  = 12;
  localparam int unsigned OP_SUB  = 11;
  localparam int unsigned OP_AND1 = 10;
  localparam int unsigned OP_NOT1 = 9;
  localparam int unsigned OP_RSR  = 8;
  localparam int unsigned OP_RSL  = 7;
  localparam int unsigned OP_JMP  = 6;
  localparam int unsigned OP_JZ   = 5;
  localparam int unsigned OP_JC   = 4;
  localparam int unsigned OP_IN1  = 3;
  localparam int unsigned OP_OUT1 = 2;
  localparam int unsigned OP_NOP  = 1;
  localparam int unsigned OP_HALT = 0;

  // Several bits set: halt > jumps > mem > in > exec; nop or nothing refetches.
  function automatic state_e decode_next(input logic [15:0] op);
    state_e st;
    if (op[OP_HALT]) begin
      st = StHalt;
    end else if (op[OP_JMP] | op[OP_JZ] | op[OP_JC]) begin
      st = StOprd;
    end else if (op[OP_MOVB] | op[OP_MOVC]) begin
      st = StMem;
    end else if (op[OP_IN1]) begin
      st = StIn;
    end else if (|{op[OP_ADD], op[OP_SUB], op[OP_AND1], op[OP_NOT1], op[OP_RSR], op[OP_RSL],
                   op[OP_MOVA], op[OP_OUT1]}) begin
      st = StExec;
    end else begin
      st = StFetch;
    end
    return st;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_wait_timer.sv
// Stall-cycle counter for the controller's handshake waits.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_clr      clear the count (state change)
//   i_cnt      one more stalled cycle
//   o_expired  count has reached WAIT_MAX
module cpu_ctrl_fsm_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_cnt,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  logic [CntW-1:0] r_cnt;

  assign o_expired = (r_cnt == CntW'(WAIT_MAX));

  // Saturates so a held count can never wrap back below WAIT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit CPU: fetch, decode, execute and memory/IO sequencing.
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request (IDLE/HALT only)
//   mem_rdy, in_vld       memory and input-port handshakes
//   flag_z, flag_c        registered ALU flags
//   dec_op                decoder one-hot result
//   dec_en .. bus_err     decoder enable, PC/IR/regfile/ALU/memory/IO strobes, status
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_rdy,
  input  logic        in_vld,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic [15:0] dec_op,
  output logic        dec_en,
  output logic        ir_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        mar_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_we,
  output logic [1:0]  reg_src,
  output logic [2:0]  alu_op,
  output logic        flag_ld,
  output logic        out_ld,
  output logic        in_ack,
  output logic        halted,
  output logic        bus_err
);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_op;
  logic        w_stall;
  logic        w_expired;
  logic        w_tmr_clr;
  logic        w_taken;
  logic        w_unused;

  // These op bits only steer DECODE; nothing downstream reads them from r_op.
  assign w_unused = ^{r_op[OP_IN1], r_op[OP_NOP], r_op[OP_HALT]};

  assign w_taken = r_op[OP_JMP] | (r_op[OP_JZ] & flag_z) | (r_op[OP_JC] & flag_c);

  // Any state change restarts the stall count, so each wait starts from zero.
  assign w_tmr_clr = (w_state_next != r_state);

  cpu_ctrl_fsm_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_tmr_clr),
    .i_cnt     (w_stall),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StDecode) begin
        r_op <= dec_op;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    dec_en       = 1'b0;
    ir_ld        = 1'b0;
    pc_clr       = 1'b0;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    mar_sel      = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_we       = 1'b0;
    reg_src      = REG_SRC_ALU;
    alu_op       = ALU_ADD;
    flag_ld      = 1'b0;
    out_ld       = 1'b0;
    in_ack       = 1'b0;
    halted       = 1'b0;
    bus_err      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          pc_clr       = 1'b1;
          w_state_next = StFetch;
        end
      end

      StFetch: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_ld        = 1'b1;
          pc_inc       = 1'b1;
          w_state_next = StDecode;
        end else begin
          w_stall = 1'b1;
        end
      end

      StDecode: begin
        dec_en       = 1'b1;
        w_state_next = decode_next(dec_op);
      end

      StExec: begin
        w_state_next = StFetch;
        reg_we       = 1'b1;
        flag_ld      = 1'b1;
        if (r_op[OP_ADD]) begin
          alu_op = ALU_ADD;
        end else if (r_op[OP_SUB]) begin
          alu_op = ALU_SUB;
        end else if (r_op[OP_AND1]) begin
          alu_op = ALU_AND;
        end else if (r_op[OP_NOT1]) begin
          alu_op = ALU_NOT;
        end else if (r_op[OP_RSR]) begin
          alu_op = ALU_RSR;
        end else if (r_op[OP_RSL]) begin
          alu_op = ALU_RSL;
        end else if (r_op[OP_MOVA]) begin
          alu_op  = ALU_PASS;
          flag_ld = 1'b0;
        end else begin
          alu_op  = ALU_PASS;
          flag_ld = 1'b0;
          reg_we  = 1'b0;
          out_ld  = r_op[OP_OUT1];
        end
      end

      StMem: begin
        mar_sel = 1'b1;
        mem_rd  = r_op[OP_MOVC];
        mem_wr  = r_op[OP_MOVB] & ~r_op[OP_MOVC];
        if (mem_rdy) begin
          reg_we       = r_op[OP_MOVC];
          reg_src      = r_op[OP_MOVC] ? REG_SRC_MEM : REG_SRC_ALU;
          w_state_next = StFetch;
        end else begin
          w_stall = 1'b1;
        end
      end

      StOprd: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          pc_ld        = w_taken;
          pc_inc       = ~w_taken;
          w_state_next = StFetch;
        end else begin
          w_stall = 1'b1;
        end
      end

      StIn: begin
        if (in_vld) begin
          in_ack       = 1'b1;
          reg_we       = 1'b1;
          reg_src      = REG_SRC_IN;
          w_state_next = StFetch;
        end else begin
          w_stall = 1'b1;
        end
      end

      StHalt: begin
        halted = 1'b1;
        if (start) begin
          w_state_next = StFetch;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Timeout: the stall that finds the counter already at WAIT_MAX aborts the access.
    if (w_stall && w_expired) begin
      bus_err      = 1'b1;
      w_state_next = StHalt;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
module tb_cpu_ctrl_fsm;

  localparam logic [15:0] D_MOVA = 16'h8000;
  localparam logic [15:0] D_MOVB = 16'h4000;
  localparam logic [15:0] D_MOVC = 16'h2000;
  localparam logic [15:0] D_ADD  = 16'h1000;
  localparam logic [15:0] D_SUB  = 16'h0800;
  localparam logic [15:0] D_RSL  = 16'h0080;
  localparam logic [15:0] D_JMP  = 16'h0040;
  localparam logic [15:0] D_JZ   = 16'h0020;
  localparam logic [15:0] D_JC   = 16'h0010;
  localparam logic [15:0] D_IN   = 16'h0008;
  localparam logic [15:0] D_OUT  = 16'h0004;
  localparam logic [15:0] D_NOP  = 16'h0002;
  localparam logic [15:0] D_HALT = 16'h0001;

  // Expected-output bits in the order of w_act below.
  localparam logic [18:0] E_NONE = 19'h00000;
  localparam logic [18:0] E_DEC  = 19'h40000;
  localparam logic [18:0] E_IR   = 19'h20000;
  localparam logic [18:0] E_CLR  = 19'h10000;
  localparam logic [18:0] E_INC  = 19'h08000;
  localparam logic [18:0] E_PCLD = 19'h04000;
  localparam logic [18:0] E_MAR  = 19'h02000;
  localparam logic [18:0] E_RD   = 19'h01000;
  localparam logic [18:0] E_WR   = 19'h00800;
  localparam logic [18:0] E_WE   = 19'h00400;
  localparam logic [18:0] E_FLG  = 19'h00010;
  localparam logic [18:0] E_OUT  = 19'h00008;
  localparam logic [18:0] E_ACK  = 19'h00004;
  localparam logic [18:0] E_HLT  = 19'h00002;
  localparam logic [18:0] E_ERR  = 19'h00001;
  localparam logic [18:0] E_FDONE = E_IR | E_INC | E_RD;

  function automatic logic [18:0] f_src(input logic [1:0] v);
    return {9'b0, v, 8'b0};
  endfunction

  function automatic logic [18:0] f_alu(input logic [2:0] v);
    return {11'b0, v, 5'b0};
  endfunction

  typedef struct {
    string       name;
    logic        st;
    logic        rdy;
    logic        vld;
    logic        z;
    logic        c;
    logic [15:0] op;
    logic [18:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_rdy;
  logic        in_vld;
  logic        flag_z;
  logic        flag_c;
  logic [15:0] dec_op;
  logic        dec_en, ir_ld, pc_clr, pc_inc, pc_ld, mar_sel, mem_rd, mem_wr, reg_we;
  logic [1:0]  reg_src;
  logic [2:0]  alu_op;
  logic        flag_ld, out_ld, in_ack, halted, bus_err;
  logic [18:0] w_act;

  int checks;
  int failures;
  vec_t tbl[$];

  cpu_ctrl_fsm #(
    .WAIT_MAX (15)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mem_rdy (mem_rdy),
    .in_vld  (in_vld),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .dec_op  (dec_op),
    .dec_en  (dec_en),
    .ir_ld   (ir_ld),
    .pc_clr  (pc_clr),
    .pc_inc  (pc_inc),
    .pc_ld   (pc_ld),
    .mar_sel (mar_sel),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .reg_we  (reg_we),
    .reg_src (reg_src),
    .alu_op  (alu_op),
    .flag_ld (flag_ld),
    .out_ld  (out_ld),
    .in_ack  (in_ack),
    .halted  (halted),
    .bus_err (bus_err)
  );

  assign w_act = {dec_en, ir_ld, pc_clr, pc_inc, pc_ld, mar_sel, mem_rd, mem_wr, reg_we,
                  reg_src, alu_op, flag_ld, out_ld, in_ack, halted, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: outputs got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic st, input logic rdy, input logic vld,
                     input logic z, input logic c, input logic [15:0] op,
                     input logic [18:0] e);
    vec_t v;
    v.name = n; v.st = st; v.rdy = rdy; v.vld = vld; v.z = z; v.c = c; v.op = op; v.exp = e;
    tbl.push_back(v);
  endtask

  // Called just after a falling edge: drive, settle, compare, then move one cycle on.
  task automatic step(input string n, input logic st, input logic rdy, input logic vld,
                      input logic z, input logic c, input logic [15:0] op,
                      input logic [18:0] e);
    start = st; mem_rdy = rdy; in_vld = vld; flag_z = z; flag_c = c; dec_op = op;
    #1;
    check(n, w_act, e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mem_rdy  = 1'b0;
    in_vld   = 1'b0;
    flag_z   = 1'b0;
    flag_c   = 1'b0;
    dec_op   = '0;

    //    name          st rdy vld z  c  dec_op           expected
    add("idle",         0, 0, 0, 0, 0, '0,              E_NONE);
    add("idle_rdy_ign", 0, 1, 0, 0, 0, '0,              E_NONE);
    add("idle_start",   1, 0, 0, 0, 0, '0,              E_CLR);
    add("fetch_stall",  0, 0, 0, 0, 0, '0,              E_RD);
    add("fetch_done",   0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_add",      0, 0, 0, 0, 0, D_ADD,           E_DEC);
    add("exec_add",     0, 0, 0, 0, 0, '0,              E_WE | f_alu(3'd0) | E_FLG);
    add("fetch_a",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_sub",      0, 0, 0, 0, 0, D_SUB,           E_DEC);
    add("exec_sub",     0, 0, 0, 0, 0, '0,              E_WE | f_alu(3'd1) | E_FLG);
    add("fetch_b",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_mova",     0, 0, 0, 0, 0, D_MOVA,          E_DEC);
    add("exec_mova",    0, 0, 0, 0, 0, '0,              E_WE | f_alu(3'd6));
    add("fetch_c",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_out",      0, 0, 0, 0, 0, D_OUT,           E_DEC);
    add("exec_out",     0, 0, 0, 0, 0, '0,              E_OUT | f_alu(3'd6));
    add("fetch_d",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_rsl",      0, 0, 0, 0, 0, D_RSL,           E_DEC);
    add("exec_rsl",     0, 0, 0, 0, 0, '0,              E_WE | f_alu(3'd5) | E_FLG);
    add("fetch_e",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_nop",      0, 0, 0, 0, 0, D_NOP,           E_DEC);
    add("nop_refetch",  0, 0, 0, 0, 0, '0,              E_RD);
    add("fetch_f",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_jz",       0, 0, 0, 1, 0, D_JZ,            E_DEC);
    add("jz_taken",     0, 1, 0, 1, 0, '0,              E_RD | E_PCLD);
    add("fetch_g",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_jz2",      0, 0, 0, 0, 0, D_JZ,            E_DEC);
    add("jz_not_taken", 0, 1, 0, 0, 0, '0,              E_RD | E_INC);
    add("fetch_h",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_jzjc",     0, 0, 0, 0, 0, D_JZ | D_JC,     E_DEC);
    add("oprd_stall",   0, 0, 0, 0, 1, '0,              E_RD);
    add("jzjc_taken",   0, 1, 0, 0, 1, '0,              E_RD | E_PCLD);
    add("fetch_i",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_jmp_add",  0, 0, 0, 0, 0, D_JMP | D_ADD,   E_DEC);
    add("jmp_taken",    0, 1, 0, 0, 0, '0,              E_RD | E_PCLD);
    add("fetch_j",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_movb",     0, 0, 0, 0, 0, D_MOVB,          E_DEC);
    add("movb_stall",   0, 0, 0, 0, 0, '0,              E_MAR | E_WR);
    add("movb_done",    0, 1, 0, 0, 0, '0,              E_MAR | E_WR);
    add("fetch_k",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_zero",     0, 0, 0, 0, 0, '0,              E_DEC);
    add("fetch_l",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_in",       0, 0, 0, 0, 0, D_IN,            E_DEC);
    add("in_wait",      0, 0, 0, 0, 0, '0,              E_NONE);
    add("in_rdy_ign",   0, 1, 0, 0, 0, '0,              E_NONE);
    add("in_take",      0, 0, 1, 0, 0, '0,              E_ACK | E_WE | f_src(2'd2));
    add("fetch_m",      0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_halt_jmp", 0, 0, 0, 0, 0, D_HALT | D_JMP,  E_DEC);
    add("halt",         0, 0, 0, 0, 0, '0,              E_HLT);
    add("halt_rdy_ign", 0, 1, 0, 0, 0, '0,              E_HLT);
    add("halt_start",   1, 0, 0, 0, 0, '0,              E_HLT);
    add("resume_fetch", 0, 1, 0, 0, 0, '0,              E_FDONE);
    add("dec_add2",     0, 0, 0, 0, 0, D_ADD,           E_DEC);
    add("exec_st_ign",  1, 0, 0, 0, 0, '0,              E_WE | E_FLG);
    add("fetch_n",      0, 0, 0, 0, 0, '0,              E_RD);

    @(negedge clk);
    #1;
    check("reset_hold", w_act, E_NONE);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].st, tbl[i].rdy, tbl[i].vld, tbl[i].z, tbl[i].c, tbl[i].op,
           tbl[i].exp);
    end

    // Reset while FETCH holds mem_rd: outputs drop without waiting for an edge.
    mem_rdy = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("reset_mid_fetch", w_act, E_NONE);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_idle",      0, 0, 0, 0, 0, '0, E_NONE);
    step("rst_start",     1, 0, 0, 0, 0, '0, E_CLR);
    step("rst_fetch",     0, 0, 0, 0, 0, '0, E_RD);

    // movc with mem_rdy on the sixth MEM cycle.
    step("movc_fetch",    0, 1, 0, 0, 0, '0, E_FDONE);
    step("movc_dec",      0, 0, 0, 0, 0, D_MOVC, E_DEC);
    for (int i = 0; i < 5; i++) begin
      step("movc_wait",   0, 0, 0, 0, 0, '0, E_MAR | E_RD);
    end
    step("movc_done",     0, 1, 0, 0, 0, '0, E_MAR | E_RD | E_WE | f_src(2'd1));

    // 15 stalled fetch cycles are tolerated; the 16th stall raises bus_err.
    for (int i = 0; i < 15; i++) begin
      step("to_stall",    0, 0, 0, 0, 0, '0, E_RD);
    end
    step("to_bus_err",    0, 0, 0, 0, 0, '0, E_RD | E_ERR);
    step("to_halted",     0, 0, 0, 0, 0, '0, E_HLT);
    step("to_restart",    1, 0, 0, 0, 0, '0, E_HLT);

    // Same wait, but mem_rdy arrives on the cycle the counter reaches WAIT_MAX.
    for (int i = 0; i < 15; i++) begin
      step("edge_stall",  0, 0, 0, 0, 0, '0, E_RD);
    end
    step("edge_rdy_wins", 0, 1, 0, 0, 0, '0, E_FDONE);
    step("edge_dec",      0, 0, 0, 0, 0, D_NOP, E_DEC);
    step("edge_refetch",  0, 0, 0, 0, 0, '0, E_RD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
